mdu_ctrl: RTL

- Multi-cycle multiply/divide unit sequencer in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E and holds the architectural HI/LO registers.
- Serves mfhi/mflo reads through a combinational read port.
- Drives `busy`, which the hazard/stall logic combines with the E-stage md decode to freeze D-stage md/mt/mf instructions.

---
 rtl/mdu_pkg.sv | 44 ++++
 rtl/mdu_arith.sv | 65 ++++++
 rtl/mdu_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the multiply/divide unit.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

  localparam int DATA_W = 32;
  localparam int RES_W  = 64;
  localparam int CNT_W  = 4;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Ops that run for MULT_CYCLES; the accumulate family only exists when enabled.
  function automatic logic op_is_mul(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for mult/div (and MDU_MADD_EN accumulate ops).
// Divide-by-zero returns the incoming {hi,lo} so the registers end up unchanged.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [RES_W-1:0]  result
);

  logic signed [RES_W-1:0]  a_ext;
  logic signed [RES_W-1:0]  b_ext;
  logic signed [RES_W-1:0]  prod_s;
  logic        [RES_W-1:0]  prod_u;
  logic        [RES_W-1:0]  acc;
  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic signed [DATA_W-1:0] sb_safe;
  logic signed [DATA_W-1:0] quot_s;
  logic signed [DATA_W-1:0] rem_s;
  logic        [DATA_W-1:0] ub_safe;
  logic        [DATA_W-1:0] quot_u;
  logic        [DATA_W-1:0] rem_u;
  logic                     div_zero;
  logic                     div_ovf;

  assign a_ext  = {{DATA_W{src_a[DATA_W-1]}}, src_a};
  assign b_ext  = {{DATA_W{src_b[DATA_W-1]}}, src_b};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};
  assign acc    = {hi_in, lo_in};

  // Divisor is forced to 1 for /0 and INT_MIN/-1 so the dividers never see an undefined case.
  assign sa       = src_a;
  assign sb       = src_b;
  assign div_zero = (src_b == '0);
  assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign sb_safe  = (div_zero || div_ovf) ? 32'sd1 : sb;
  assign quot_s   = div_ovf ? 32'sh8000_0000 : (sa / sb_safe);
  assign rem_s    = div_ovf ? 32'sd0 : (sa % sb_safe);
  assign ub_safe  = div_zero ? 32'd1 : src_b;
  assign quot_u   = src_a / ub_safe;
  assign rem_u    = src_a % ub_safe;

  always_comb begin
    result = acc;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = div_zero ? acc : {rem_s, quot_s};
      MDU_DIVU:  result = div_zero ? acc : {rem_u, quot_u};
`ifdef MDU_MADD_EN
      MDU_MADD:  result = acc + prod_s;
      MDU_MADDU: result = acc + prod_u;
      MDU_MSUB:  result = acc - prod_s;
      MDU_MSUBU: result = acc - prod_u;
`endif
      default:   result = acc;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU sequencer holding architectural HI/LO for the E stage.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cancel,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  input  logic              rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sh_hi;
  logic [DATA_W-1:0] sh_lo;
  logic [RES_W-1:0]  arith_result;
  logic              accept;
  logic              is_mul;
  logic              is_div;

  mdu_arith u_arith (
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi_in  (hi),
    .lo_in  (lo),
    .result (arith_result)
  );

  assign accept  = start & ~cancel & (state == ST_IDLE);
  assign is_mul  = op_is_mul(op);
  assign is_div  = op_is_div(op);
  assign busy    = (state == ST_RUN);
  assign rd_data = rd_sel ? hi : lo;

  // The result is captured into the shadow at accept and only exposed on the last busy cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sh_hi <= '0;
      sh_lo <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul || is_div) begin
              {sh_hi, sh_lo} <= arith_result;
              cnt            <= is_div ? DIV_CNT : MULT_CNT;
              state          <= ST_RUN;
            end else if (op == MDU_MTHI) begin
              hi <= src_a;
            end else if (op == MDU_MTLO) begin
              lo <= src_a;
            end
          end
        end
        default: begin
          if (cnt == CNT_W'(1)) begin
            hi    <= sh_hi;
            lo    <= sh_lo;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset_n && state == ST_RUN && !cancel)
      assert (!start) else $error("mdu_ctrl: start asserted while busy");
  end

endmodule
